// File: rtl/mux21_arbiter.sv
// mux21_arbiter: two-requester round-robin arbiter with burst limit driving a registered 2:1 mux.
module mux21_arbiter #(
    parameter int DATA_W = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1,
    input  logic              req2,
    input  logic [DATA_W-1:0] D1,
    input  logic [DATA_W-1:0] D2,
    output logic              gnt1,
    output logic              gnt2,
    output logic              S,
    output logic [DATA_W-1:0] Y,
    output logic              Y_valid
);
    typedef enum logic [1:0] {IDLE, G1, G2} state_t;
    localparam logic [3:0] MB = MAX_BURST[3:0];
    state_t state, nxt, other_st;
    logic [3:0] cnt, cnt_nxt;
    logic last2, mine, other, at_max;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            last2 <= 1'b1;
        end else begin
            state <= nxt;
            cnt <= cnt_nxt;
            if (nxt != IDLE && nxt != state) last2 <= (nxt == G2);
        end
    end
    always_comb begin
        mine = (state == G1) ? req1 : req2;
        other = (state == G1) ? req2 : req1;
        other_st = (state == G1) ? G2 : G1;
        at_max = (cnt == MB);
        nxt = (state == IDLE) ? ((req1 && req2) ? (last2 ? G1 : G2) : req1 ? G1 : req2 ? G2 : IDLE)
            : (mine && !at_max) ? state : other ? other_st : mine ? state : IDLE;
        cnt_nxt = (nxt == IDLE) ? 4'd0 : (nxt == state && !at_max) ? cnt + 4'd1 : 4'd1;
    end
    always_comb begin
        gnt1 = (state == G1);
        gnt2 = (state == G2);
        S = (state == G2);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            Y <= '0;
            Y_valid <= 1'b0;
        end else begin
            if (state != IDLE) Y <= S ? D2 : D1;
            Y_valid <= (state != IDLE);
        end
    end
endmodule

// File: tb/tb_mux21_arbiter.sv
// tb_mux21_arbiter: scoreboard bench comparing the arbiter against a rule-level grant model.
module tb_mux21_arbiter;
    localparam int MB = 4;
    typedef struct packed {
        logic g1;
        logic g2;
        logic s;
        logic [7:0] y;
        logic yv;
    } exp_t;
    logic clk = 0, rst = 0, req1 = 0, req2 = 0;
    logic [7:0] D1 = 0, D2 = 0, Y;
    logic gnt1, gnt2, S, Y_valid;
    exp_t q[$];
    int vectors = 0, miscompares = 0;
    int owner = 0, run = 0, last = 2, wait1 = 0, wait2 = 0;
    logic [7:0] my = 0;
    logic myv = 0;

    mux21_arbiter #(.DATA_W(8), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2), .D1(D1), .D2(D2),
        .gnt1(gnt1), .gnt2(gnt2), .S(S), .Y(Y), .Y_valid(Y_valid)
    );

    always #5 clk = ~clk;

    // Who owns the mux after the edge: the holder keeps it while requesting and under its
    // burst quota, otherwise a waiting peer takes over; a lone requester keeps it.
    task automatic step(input logic r, input logic a, input logic b, input logic [7:0] d1, input logic [7:0] d2);
        int nxt;
        logic mine, oth;
        @(negedge clk);
        rst = r; req1 = a; req2 = b; D1 = d1; D2 = d2;
        if (r) begin
            owner = 0; run = 0; last = 2; my = 0; myv = 0;
        end else begin
            myv = (owner != 0);
            if (owner != 0) my = (owner == 2) ? d2 : d1;
            if (owner == 0) nxt = (a && b) ? 3 - last : a ? 1 : b ? 2 : 0;
            else begin
                mine = (owner == 1) ? a : b;
                oth = (owner == 1) ? b : a;
                if (mine && run < MB) nxt = owner;
                else if (oth) nxt = 3 - owner;
                else if (mine) nxt = owner;
                else nxt = 0;
            end
            run = (nxt == 0) ? 0 : (nxt == owner && run < MB) ? run + 1 : 1;
            if (nxt != 0 && nxt != owner) last = nxt;
            owner = nxt;
        end
        q.push_back({owner == 1, owner == 2, owner == 2, my, myv});
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if ({gnt1, gnt2, S, Y, Y_valid} !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got g1=%b g2=%b S=%b Y=%h V=%b want g1=%b g2=%b S=%b Y=%h V=%b",
                         $time, gnt1, gnt2, S, Y, Y_valid, e.g1, e.g2, e.s, e.y, e.yv);
            end
            vectors++;
            if (gnt1 && gnt2) begin
                miscompares++;
                $display("FAIL mutex t=%0t got gnt1=%b gnt2=%b want not both", $time, gnt1, gnt2);
            end
            wait1 = (rst || !req1 || gnt1) ? 0 : wait1 + 1;
            wait2 = (rst || !req2 || gnt2) ? 0 : wait2 + 1;
            vectors++;
            if (wait1 > MB || wait2 > MB) begin
                miscompares++;
                $display("FAIL starvation t=%0t got wait1=%0d wait2=%0d want <= %0d", $time, wait1, wait2, MB);
            end
        end
    end

    initial begin
        step(1, 0, 0, 8'h00, 8'h00);
        step(1, 1, 1, 8'h00, 8'h00);
        for (int i = 0; i < 14; i++) step(0, 1, 1, 8'h0A, 8'hA0);
        step(0, 0, 0, 8'h11, 8'h22);
        step(0, 0, 0, 8'h11, 8'h22);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h33, 8'h55);
        step(0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 1, 8'h61, 8'h62);
        step(0, 1, 1, 8'h63, 8'h64);
        step(0, 0, 1, 8'h65, 8'h66);
        step(0, 0, 1, 8'h67, 8'h68);
        step(0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'h71, 8'h72);
        step(0, 1, 0, 8'h73, 8'h74);
        step(0, 0, 0, 8'h75, 8'h76);
        step(0, 0, 0, 8'h77, 8'h78);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h81, 8'h82);
        step(1, 0, 1, 8'h83, 8'h84);
        step(0, 1, 1, 8'h85, 8'h86);
        step(0, 1, 1, 8'h87, 8'h88);
        step(0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 1000; i++)
            step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
